// File: rtl/game_controller.sv
// rtl/game_controller.sv - 2048 move-pass sequencer: button edges to row shifts, tile spawns and win/loss check
module game_controller #(
  parameter int N        = 4,
  parameter int GOAL_LOG = 11,
  localparam int SW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_start,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          row_done,
  input  logic          row_moved,
  input  logic          spawn_ack,
  input  logic [3:0]    max_tile_log,
  input  logic          board_full,
  input  logic          merge_possible,
  output logic          board_clr,
  output logic          row_start,
  output logic [SW-1:0] row_sel,
  output logic [1:0]    dir,
  output logic          spawn_req,
  output logic [2:0]    state,
  output logic          won,
  output logic          lost,
  output logic          busy,
  output logic [15:0]   move_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_SPAWN = 3'd4,
    S_CHECK = 3'd5,
    S_WON   = 3'd6,
    S_LOST  = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [SW-1:0]   row_sel_q, row_sel_d;
  logic [15:0]     move_count_q, move_count_d;
  logic [1:0]      spawn_cnt_q, spawn_cnt_d;
  logic            moved_acc_q, moved_acc_d;
  logic            launched_q, launched_d;
  logic            gap_q, gap_d;
  logic [4:0]      btn_prev_q;

  logic [4:0]      btn_now;
  logic [4:0]      btn_edge;
  logic            start_edge;
  logic            dir_go;
  logic [1:0]      dir_new;

  assign btn_now    = {btn_start, btn_right, btn_left, btn_down, btn_up};
  assign btn_edge   = btn_now & ~btn_prev_q;
  assign start_edge = btn_edge[4];

  // A move needs exactly one direction edge; chords are discarded.
  always_comb begin
    dir_go  = 1'b1;
    dir_new = 2'd0;
    case (btn_edge[3:0])
      4'b0001: dir_new = 2'd0;
      4'b0010: dir_new = 2'd1;
      4'b0100: dir_new = 2'd2;
      4'b1000: dir_new = 2'd3;
      default: dir_go  = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    row_sel_d    = row_sel_q;
    move_count_d = move_count_q;
    spawn_cnt_d  = spawn_cnt_q;
    moved_acc_d  = moved_acc_q;
    launched_d   = launched_q;
    gap_d        = gap_q;
    board_clr    = 1'b0;
    row_start    = 1'b0;
    spawn_req    = 1'b0;

    case (state_q)
      S_IDLE, S_WON, S_LOST: begin
        if (start_edge) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        board_clr    = 1'b1;
        move_count_d = 16'd0;
        spawn_cnt_d  = 2'd2;
        gap_d        = 1'b0;
        state_d      = S_SPAWN;
      end
      S_WAIT: begin
        if (start_edge) begin
          state_d = S_CLEAR;
        end else if (dir_go) begin
          dir_d       = dir_new;
          row_sel_d   = '0;
          moved_acc_d = 1'b0;
          launched_d  = 1'b0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // launched_q masks row_done during the row_start cycle.
        if (!launched_q) begin
          row_start  = 1'b1;
          launched_d = 1'b1;
        end else if (row_done) begin
          launched_d  = 1'b0;
          moved_acc_d = moved_acc_q | row_moved;
          if (row_sel_q != SW'(N - 1)) begin
            row_sel_d = row_sel_q + SW'(1);
          end else if (moved_acc_q | row_moved) begin
            if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
            spawn_cnt_d = 2'd1;
            gap_d       = 1'b0;
            state_d     = S_SPAWN;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_SPAWN: begin
        if (spawn_cnt_q == 2'd0) begin
          state_d = S_CHECK;
        end else if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          spawn_req = 1'b1;
          if (spawn_ack) begin
            spawn_cnt_d = spawn_cnt_q - 2'd1;
            gap_d       = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (int'(max_tile_log) >= GOAL_LOG)       state_d = S_WON;
        else if (board_full && !merge_possible)  state_d = S_LOST;
        else                                     state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      dir_q        <= 2'd0;
      row_sel_q    <= '0;
      move_count_q <= 16'd0;
      spawn_cnt_q  <= 2'd0;
      moved_acc_q  <= 1'b0;
      launched_q   <= 1'b0;
      gap_q        <= 1'b0;
      btn_prev_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      row_sel_q    <= row_sel_d;
      move_count_q <= move_count_d;
      spawn_cnt_q  <= spawn_cnt_d;
      moved_acc_q  <= moved_acc_d;
      launched_q   <= launched_d;
      gap_q        <= gap_d;
      btn_prev_q   <= btn_now;
    end
  end

  assign state      = state_q;
  assign dir        = dir_q;
  assign row_sel    = row_sel_q;
  assign move_count = move_count_q;
  assign won        = (state_q == S_WON);
  assign lost       = (state_q == S_LOST);
  assign busy       = (state_q == S_CLEAR) || (state_q == S_SHIFT) ||
                      (state_q == S_SPAWN) || (state_q == S_CHECK);

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - randomized self-checking bench for game_controller
module tb_game_controller;
  localparam int N    = 4;
  localparam int GOAL = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        row_done = 1'b0, row_moved = 1'b0, spawn_ack = 1'b0;
  logic [3:0]  max_tile_log = 4'd0;
  logic        board_full = 1'b0, merge_possible = 1'b0;
  logic        board_clr, row_start, spawn_req, won, lost, busy;
  logic [1:0]  row_sel;
  logic [1:0]  dir;
  logic [2:0]  state;
  logic [15:0] move_count;

  int          n_checks = 0;
  int          n_err = 0;
  logic [15:0] m_count = 16'd0;

  game_controller #(.N(N), .GOAL_LOG(GOAL)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .row_done(row_done), .row_moved(row_moved), .spawn_ack(spawn_ack),
    .max_tile_log(max_tile_log), .board_full(board_full), .merge_possible(merge_possible),
    .board_clr(board_clr), .row_start(row_start), .row_sel(row_sel), .dir(dir),
    .spawn_req(spawn_req), .state(state), .won(won), .lost(lost), .busy(busy),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  // b = {start, right, left, down, up}; level high for one cycle only.
  task automatic press(input logic [4:0] b);
    {btn_start, btn_right, btn_left, btn_down, btn_up} = b;
    @(negedge clk);
    {btn_start, btn_right, btn_left, btn_down, btn_up} = 5'b0;
  endtask

  task automatic spawn_phase(input int n);
    int   acks;
    int   cyc;
    int   dly;
    logic owed;
    acks = 0; cyc = 0; owed = 1'b0;
    dly  = $urandom_range(0, 2);
    while (state == 3'd4 && cyc < 40) begin
      if (owed) check("spawn_hold", 32'(spawn_req), 1);
      if (spawn_req) begin
        if (dly == 0) begin
          spawn_ack = 1'b1; acks++; owed = 1'b0; dly = $urandom_range(0, 2);
        end else begin
          spawn_ack = 1'b0; owed = 1'b1; dly--;
        end
      end else begin
        spawn_ack = 1'($urandom % 2);
        owed = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    spawn_ack = 1'b0;
    check("spawn_acks", 32'(acks), 32'(n));
  endtask

  task automatic do_row(input int r, input int d, input logic mv);
    check("row_start", 32'(row_start), 1);
    check("row_sel", 32'(row_sel), 32'(r));
    check("dir", 32'(dir), 32'(d));
    row_done = 1'($urandom % 2);
    row_moved = 1'b1;
    @(negedge clk);
    row_done = 1'b0; row_moved = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      check("row_start_low", 32'(row_start), 0);
      @(negedge clk);
    end
    row_done = 1'b1; row_moved = mv;
    @(negedge clk);
    row_done = 1'b0; row_moved = 1'b0;
  endtask

  task automatic start_game();
    max_tile_log = 4'd0; board_full = 1'b0; merge_possible = 1'b0;
    press(5'b10000);
    check("clear_state", 32'(state), 1);
    check("clear_pulse", 32'(board_clr), 1);
    check("clear_busy", 32'(busy), 1);
    @(negedge clk);
    check("clear_once", 32'(board_clr), 0);
    check("init_spawn_state", 32'(state), 4);
    check("init_count", 32'(move_count), 0);
    spawn_phase(2);
    check("init_check", 32'(state), 5);
    @(negedge clk);
    check("init_wait", 32'(state), 2);
    check("init_busy", 32'(busy), 0);
    m_count = 16'd0;
  endtask

  // Returns the settled state so the caller knows whether the game ended.
  task automatic do_move(input int d, input logic [3:0] mask, input logic [3:0] mt,
                         input logic fu, input logic mg, output logic [2:0] exp_st);
    max_tile_log = mt; board_full = fu; merge_possible = mg;
    press(5'(1 << d));
    check("shift_entry", 32'(state), 3);
    for (int r = 0; r < N; r++) do_row(r, d, mask[r]);
    if (mask != 4'd0) begin
      if (m_count != 16'hFFFF) m_count++;
      check("spawn_entry", 32'(state), 4);
      spawn_phase(1);
      check("check_state", 32'(state), 5);
      @(negedge clk);
      if (int'(mt) >= GOAL)   exp_st = 3'd6;
      else if (fu && !mg)     exp_st = 3'd7;
      else                    exp_st = 3'd2;
    end else begin
      exp_st = 3'd2;
    end
    check("move_end_state", 32'(state), 32'(exp_st));
    check("move_end_req", 32'(spawn_req), 0);
    check("move_count", 32'(move_count), 32'(m_count));
    check("won", 32'(won), 32'(exp_st == 3'd6));
    check("lost", 32'(lost), 32'(exp_st == 3'd7));
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic chord();
    logic [3:0] m;
    do m = 4'($urandom % 16); while ($countones(m) < 2);
    press({1'b0, m});
    check("chord_state", 32'(state), 2);
    check("chord_row_start", 32'(row_start), 0);
    @(negedge clk);
    check("chord_hold", 32'(state), 2);
  endtask

  task automatic ignore_dir_then_restart(input logic [2:0] st);
    press(5'(1 << $urandom_range(0, 3)));
    check("end_hold", 32'(state), 32'(st));
    check("end_no_row", 32'(row_start), 0);
    start_game();
  endtask

  initial begin
    logic [2:0] st;
    logic [3:0] mask;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_outputs", 32'({board_clr, row_start, spawn_req, won, lost, busy}), 0);
    check("rst_row_sel", 32'(row_sel), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_count", 32'(move_count), 0);
    rst = 1'b1;
    @(negedge clk);
    press(5'b00100);
    check("idle_ignores_dir", 32'(state), 0);
    @(negedge clk);
    start_game();

    do_move(2, 4'b0100, 4'd3, 1'b0, 1'b0, st);
    do_move(0, 4'b0000, 4'd3, 1'b0, 1'b0, st);
    press(5'b01001);
    check("chord_up_right", 32'(state), 2);
    check("chord_no_start", 32'(row_start), 0);
    @(negedge clk);

    do_move(3, 4'b1001, 4'd11, 1'b1, 1'b0, st);
    check("directed_won", 32'(st), 6);
    ignore_dir_then_restart(st);
    do_move(1, 4'b0010, 4'd10, 1'b1, 1'b0, st);
    check("directed_lost", 32'(st), 7);
    ignore_dir_then_restart(st);

    press(5'b00100);
    do_row(0, 2, 1'b1);
    do_row(1, 2, 1'b0);
    check("mid_row_start", 32'(row_sel), 2);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_row_sel", 32'(row_sel), 0);
    check("mid_rst_req", 32'(spawn_req), 0);
    check("mid_rst_busy", 32'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(state), 0);
    start_game();

    for (int it = 0; it < 60; it++) begin
      case ($urandom % 10)
        0: chord();
        1: begin
          do_move(0, 4'b0001, 4'd1, 1'b0, 1'b0, st);
          start_game();
          check("restart_count", 32'(move_count), 0);
        end
        default: begin
          mask = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom % 16);
          do_move($urandom_range(0, 3), mask, 4'($urandom % 16),
                  1'($urandom % 2), 1'($urandom % 2), st);
          if (st != 3'd2) ignore_dir_then_restart(st);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
